// File: rtl/queue_serializer.sv
// queue_serializer
//   Transmit end of the byte queue: dequeues one byte at a time and shifts it
//   out MSB first over a valid/ready bit handshake. Each word is followed by
//   GAP_CYCLES idle cycles.
//
//   Optional feature macro: PARITY_EN -- appends an even-parity bit (XOR of
//   the 8 data bits) after bit 0, making each word 9 bits long.
//
// Ports
//   clock_10k         in   system clock
//   reset             in   asynchronous, active-high reset
//   q_len_in[3:0]     in   queue occupancy
//   q_data_in[7:0]    in   queue head, valid from the edge after a dequeue
//   q_deq_out         out  one-cycle dequeue pulse
//   ready_in          in   downstream accepts the presented bit this cycle
//   serial_out        out  presented bit
//   serial_valid_out  out  serial_out holds a valid bit
//   frame_start_out   out  first bit of a word is presented
//   busy_out          out  not idle
//   word_count_out    out  words fully transmitted since reset (wraps)

module queue_serializer #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock_10k,
    input  logic             reset,
    input  logic [3:0]       q_len_in,
    input  logic [7:0]       q_data_in,
    output logic             q_deq_out,
    input  logic             ready_in,
    output logic             serial_out,
    output logic             serial_valid_out,
    output logic             frame_start_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] word_count_out
);

    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
`ifdef PARITY_EN
        ,
        ST_PAR   = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
`ifdef PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               q_deq_q, q_deq_d;
    logic               serial_q, serial_d;
    logic               valid_q, valid_d;
    logic               frame_q, frame_d;
    logic               busy_q, busy_d;

    logic               word_done;

    // State, datapath and registered outputs
    always_ff @(posedge clock_10k or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            gap_cnt_q    <= '0;
            word_count_q <= '0;
`ifdef PARITY_EN
            parity_q     <= 1'b0;
`endif
            q_deq_q      <= 1'b0;
            serial_q     <= 1'b0;
            valid_q      <= 1'b0;
            frame_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_count_q <= word_count_d;
`ifdef PARITY_EN
            parity_q     <= parity_d;
`endif
            q_deq_q      <= q_deq_d;
            serial_q     <= serial_d;
            valid_q      <= valid_d;
            frame_q      <= frame_d;
            busy_q       <= busy_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        gap_cnt_d    = gap_cnt_q;
        word_count_d = word_count_q;
`ifdef PARITY_EN
        parity_d     = parity_q;
`endif
        word_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Occupancy is only looked at here, so the post-dequeue
                // decrement can never trigger a second dequeue mid-word.
                if (q_len_in != 4'd0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                shreg_d  = q_data_in;
                bitcnt_d = 3'd0;
`ifdef PARITY_EN
                parity_d = ^q_data_in;
`endif
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ready_in) begin
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = ST_PAR;
`else
                        word_done = 1'b1;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            ST_PAR: begin
                if (ready_in) begin
                    word_done = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Word count advances on the edge that accepts the final bit
        if (word_done) begin
            word_count_d = word_count_q + CNT_W'(1);
            gap_cnt_d    = '0;
            if (GAP_CYCLES > 0) begin
                state_d = ST_GAP;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Outputs decoded from the next state so they register in step with it
    always_comb begin
        q_deq_d  = 1'b0;
        serial_d = 1'b0;
        valid_d  = 1'b0;
        frame_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);

        case (state_d)
            ST_REQ: begin
                q_deq_d = 1'b1;
            end
            ST_SHIFT: begin
                valid_d  = 1'b1;
                serial_d = shreg_d[7];
                frame_d  = (bitcnt_d == 3'd0);
            end
`ifdef PARITY_EN
            ST_PAR: begin
                valid_d  = 1'b1;
                serial_d = parity_d;
            end
`endif
            default: begin
            end
        endcase
    end

    assign q_deq_out        = q_deq_q;
    assign serial_out       = serial_q;
    assign serial_valid_out = valid_q;
    assign frame_start_out  = frame_q;
    assign busy_out         = busy_q;
    assign word_count_out   = word_count_q;

endmodule

// File: tb/tb_queue_serializer.sv
`timescale 1us/1ns
// Testbench for queue_serializer: emulates the byte queue and checks the
// serial stream against a per-word bit list built from the queued bytes.

module tb_queue_serializer;

    localparam int unsigned GAP = 1;
    localparam int unsigned CW  = 16;
`ifdef PARITY_EN
    localparam int WORD_BITS = 9;
`else
    localparam int WORD_BITS = 8;
`endif

    logic          clock_10k = 1'b0;
    logic          reset;
    logic [3:0]    q_len_in;
    logic [7:0]    q_data_in;
    logic          q_deq_out;
    logic          ready_in;
    logic          serial_out;
    logic          serial_valid_out;
    logic          frame_start_out;
    logic          busy_out;
    logic [CW-1:0] word_count_out;

    queue_serializer #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clock_10k        (clock_10k),
        .reset            (reset),
        .q_len_in         (q_len_in),
        .q_data_in        (q_data_in),
        .q_deq_out        (q_deq_out),
        .ready_in         (ready_in),
        .serial_out       (serial_out),
        .serial_valid_out (serial_valid_out),
        .frame_start_out  (frame_start_out),
        .busy_out         (busy_out),
        .word_count_out   (word_count_out)
    );

    always #50 clock_10k = ~clock_10k;

    logic [7:0] tbq[$];
    bit         exp_bits[$];
    int passed = 0, failed = 0, total = 0;
    int exp_wc = 0, bit_in_word = 0, gap_left = 0, stall_left = 0;
    int ready_mode = 0, cyc = 0, last_deq_cyc = 0, deq_cnt = 0;
    bit deq_pending = 0, stall_hold = 0, stall_bit = 0, prev_deq = 0;
    bit have_prev = 0, exact_spacing = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int ones = 0;
        tbq.push_back(b);
        q_len_in = 4'(tbq.size());
        for (int i = 7; i >= 0; i--) begin
            exp_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
`ifdef PARITY_EN
        exp_bits.push_back((ones % 2) == 1);
`endif
    endtask

    task automatic clear_model();
        tbq.delete();
        exp_bits.delete();
        q_len_in = 4'd0;
        exp_wc = 0; bit_in_word = 0; gap_left = 0;
        deq_pending = 0; stall_hold = 0; prev_deq = 0; have_prev = 0;
    endtask

    // One clock: queue update, per-cycle checks, ready choice, bit acceptance
    task automatic tick();
        @(posedge clock_10k);
        #1;
        cyc++;
        if (deq_pending) begin
            q_data_in = tbq.pop_front();
            q_len_in = 4'(tbq.size());
            deq_pending = 0;
        end
        check("word_count", 32'(word_count_out), 32'(exp_wc % (1 << CW)));
        if (gap_left > 0) begin
            check("gap_valid", 32'(serial_valid_out), 32'd0);
            check("gap_busy", 32'(busy_out), 32'd1);
            gap_left--;
        end
        if (stall_hold) begin
            check("stall_valid", 32'(serial_valid_out), 32'd1);
            check("stall_hold", 32'(serial_out), 32'(stall_bit));
        end
        if (bit_in_word != 0)
            check("mid_word_valid", 32'(serial_valid_out), 32'd1);
        if (serial_valid_out) begin
            check("frame_start", 32'(frame_start_out), 32'(bit_in_word == 0));
            check("valid_busy", 32'(busy_out), 32'd1);
        end else begin
            check("frame_idle", 32'(frame_start_out), 32'd0);
        end
        if (q_deq_out) begin
            check("deq_nonempty", 32'(tbq.size() != 0), 32'd1);
            check("deq_single", 32'(prev_deq), 32'd0);
            if (have_prev) begin
                if (exact_spacing)
                    check("deq_spacing", 32'(cyc - last_deq_cyc), 32'(WORD_BITS + GAP + 3));
                else
                    check("deq_min_spacing", 32'(cyc - last_deq_cyc >= WORD_BITS + GAP + 3), 32'd1);
            end
            have_prev = 1;
            last_deq_cyc = cyc;
            deq_cnt++;
            deq_pending = (tbq.size() != 0);
        end
        prev_deq = q_deq_out;

        case (ready_mode)
            1: ready_in = ($urandom_range(0, 3) != 0);
            2: begin
                if (serial_valid_out && bit_in_word == 2 && stall_left > 0) begin
                    ready_in = 1'b0;
                    stall_left--;
                    check("stall_bit2", 32'(serial_out), 32'd1);
                end else begin
                    ready_in = 1'b1;
                end
            end
            default: ready_in = 1'b1;
        endcase

        if (serial_valid_out && ready_in) begin
            check("bit_expected", 32'(exp_bits.size() != 0), 32'd1);
            if (exp_bits.size() != 0) begin
                check("serial_bit", 32'(serial_out), 32'(exp_bits.pop_front()));
                bit_in_word++;
                if (bit_in_word == WORD_BITS) begin
                    bit_in_word = 0;
                    exp_wc++;
                    gap_left = GAP;
                end
            end
        end
        stall_hold = serial_valid_out && !ready_in;
        stall_bit  = serial_out;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (n < budget && (tbq.size() != 0 || exp_bits.size() != 0 || busy_out || deq_pending)) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        reset = 1'b1;
        q_len_in = 4'd0;
        q_data_in = 8'd0;
        ready_in = 1'b1;
        repeat (3) tick();
        check("rst_deq", 32'(q_deq_out), 32'd0);
        check("rst_valid", 32'(serial_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_wc", 32'(word_count_out), 32'd0);
        #5 reset = 1'b0;

        // Idle with an empty queue
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_deq", 32'(q_deq_out), 32'd0);
            check("idle_valid", 32'(serial_valid_out), 32'd0);
            check("idle_busy", 32'(busy_out), 32'd0);
        end

        // Single byte with start latency
        d0 = deq_cnt;
        push_byte(8'hA5);
        n = 0;
        while (n < 20 && !serial_valid_out) begin
            tick();
            n++;
        end
        check("start_latency", 32'(n), 32'd3);
        drain(100);
        check("single_deq_count", 32'(deq_cnt - d0), 32'd1);
        check("single_wc", 32'(word_count_out), 32'd1);

        // Back-to-back words with ready held high
        d0 = deq_cnt;
        have_prev = 0;
        exact_spacing = 1;
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        drain(200);
        exact_spacing = 0;
        check("b2b_deq_count", 32'(deq_cnt - d0), 32'd3);
        check("b2b_wc", 32'(word_count_out), 32'd4);

        // Backpressure on bit 2 of 0x3C
        ready_mode = 2;
        stall_left = 5;
        push_byte(8'h3C);
        drain(200);
        check("stall_consumed", 32'(stall_left), 32'd0);
        ready_mode = 0;

`ifdef PARITY_EN
        // Parity: 0x07 -> 1, 0x03 -> 0 (model appends the parity bit)
        push_byte(8'h07);
        push_byte(8'h03);
        drain(200);
`endif

        // Randomized bytes and ready
        ready_mode = 1;
        have_prev = 0;
        for (int w = 0; w < 40; w++) begin
            for (int g = 0; g < 2000 && tbq.size() >= 8; g++) tick();
            push_byte(8'($urandom));
            repeat ($urandom_range(0, 15)) tick();
        end
        drain(5000);
        ready_mode = 0;

        // Reset mid-word on 0xF0 after bit 3 has been accepted
        push_byte(8'hF0);
        n = 0;
        while (n < 50 && bit_in_word < 4) begin
            tick();
            n++;
        end
        check("midword_reach", 32'(bit_in_word), 32'd4);
        tick();
        #2 reset = 1'b1;
        #1;
        check("async_serial", 32'(serial_out), 32'd0);
        check("async_valid", 32'(serial_valid_out), 32'd0);
        check("async_frame", 32'(frame_start_out), 32'd0);
        check("async_busy", 32'(busy_out), 32'd0);
        check("async_deq", 32'(q_deq_out), 32'd0);
        check("async_wc", 32'(word_count_out), 32'd0);
        clear_model();
        #10 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_deq", 32'(q_deq_out), 32'd0);
            check("post_rst_valid", 32'(serial_valid_out), 32'd0);
        end
        check("post_rst_wc", 32'(word_count_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
